// File: rtl/varint_encoder.sv
// rtl/varint_encoder.sv - protobuf base-128 varint serialiser, one byte per output beat
module varint_encoder #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_idx
);

    localparam int MAX_BYTES = (DATA_W + 6) / 7;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              more;

    // Bits above the current 7-bit group decide the continuation flag.
    assign more = |rem_q[DATA_W-1:7];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = in_val;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (!more) begin
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q >> 7;
                        // Saturate so the index can never run past the last legal byte.
                        if (idx_q != IDX_W'(MAX_BYTES - 1))
                            idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs come only from registers; gated to zero outside EMIT.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_byte  = (state_q == EMIT) ? {more, rem_q[6:0]} : 8'h00;
    assign out_last  = (state_q == EMIT) && !more;
    assign out_idx   = (state_q == EMIT) ? idx_q : '0;

endmodule

// File: tb/tb_varint_encoder.sv
// tb/tb_varint_encoder.sv - directed self-checking bench for varint_encoder
module tb_varint_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_val;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [3:0]  out_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] cap_byte [0:15];
    logic [3:0] cap_idx  [0:15];
    logic       cap_last [0:15];
    int         cap_n;

    varint_encoder #(.DATA_W(64), .IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [63:0] v);
        int n;
        in_valid = 1'b1;
        in_val   = v;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect();
        cap_n     = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) begin
                cap_byte[cap_n] = out_byte;
                cap_idx[cap_n]  = out_idx;
                cap_last[cap_n] = out_last;
                cap_n++;
            end
            @(posedge clk); #1;
            if (cap_n > 0 && cap_last[cap_n-1]) break;
            if (cap_n >= 16) break;
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (out_byte !== 8'h00) begin tests_failed++; $display("FAIL reset_out_byte got %h want 00", out_byte); end
        tests_run++;
        if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last got %b want 0", out_last); end
        tests_run++;
        if (out_idx !== 4'd0) begin tests_failed++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        send(64'd0);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL zero_latency out_valid got %b want 1", out_valid); end
        collect();
        tests_run++;
        if (cap_n !== 1) begin tests_failed++; $display("FAIL zero_count got %0d want 1", cap_n); end
        tests_run++;
        if (cap_byte[0] !== 8'h00 || cap_last[0] !== 1'b1 || cap_idx[0] !== 4'd0) begin
            tests_failed++;
            $display("FAIL zero_beat got byte=%h last=%b idx=%0d want 00/1/0", cap_byte[0], cap_last[0], cap_idx[0]);
        end
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_return in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_300();
        logic [7:0] exp_b [0:1];
        exp_b[0] = 8'hAC; exp_b[1] = 8'h02;
        send(64'd300);
        collect();
        tests_run++;
        if (cap_n !== 2) begin tests_failed++; $display("FAIL v300_count got %0d want 2", cap_n); end
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (cap_byte[i] !== exp_b[i] || cap_idx[i] !== 4'(i) || cap_last[i] !== (i == 1)) begin
                tests_failed++;
                $display("FAIL v300_beat%0d got byte=%h idx=%0d last=%b want %h/%0d/%b",
                         i, cap_byte[i], cap_idx[i], cap_last[i], exp_b[i], i, (i == 1));
            end
        end
    endtask

    task automatic test_zigzag();
        send(64'd4);
        collect();
        tests_run++;
        if (cap_n !== 1 || cap_byte[0] !== 8'h04 || cap_last[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL zz_pos2 got n=%0d byte=%h last=%b want 1/04/1", cap_n, cap_byte[0], cap_last[0]);
        end
        send(64'd3);
        collect();
        tests_run++;
        if (cap_n !== 1 || cap_byte[0] !== 8'h03 || cap_last[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL zz_neg2 got n=%0d byte=%h last=%b want 1/03/1", cap_n, cap_byte[0], cap_last[0]);
        end
        send(64'hFFFF_FFFF_FFFF_FFFF);
        collect();
        tests_run++;
        if (cap_n !== 10) begin tests_failed++; $display("FAIL max_count got %0d want 10", cap_n); end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (cap_byte[i] !== ((i == 9) ? 8'h01 : 8'hFF) || cap_idx[i] !== 4'(i) || cap_last[i] !== (i == 9)) begin
                tests_failed++;
                $display("FAIL max_beat%0d got byte=%h idx=%0d last=%b want %h/%0d/%b",
                         i, cap_byte[i], cap_idx[i], cap_last[i], (i == 9) ? 8'h01 : 8'hFF, i, (i == 9));
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(64'd300);
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_byte !== 8'hAC || out_idx !== 4'd0 || out_last !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold%0d got valid=%b byte=%h idx=%0d last=%b want 1/ac/0/0",
                         c, out_valid, out_byte, out_idx, out_last);
            end
            @(posedge clk); #1;
        end
        collect();
        tests_run++;
        if (cap_n !== 2 || cap_byte[0] !== 8'hAC || cap_byte[1] !== 8'h02 || cap_last[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release got n=%0d b0=%h b1=%h last1=%b want 2/ac/02/1",
                     cap_n, cap_byte[0], cap_byte[1], cap_last[1]);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_val    = 64'h3FFF;
        @(posedge clk); #1;
        in_val = 64'd2;
        tests_run++;
        if (in_ready !== 1'b0 || out_byte !== 8'hFF || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_beat0 got rdy=%b byte=%h last=%b want 0/ff/0", in_ready, out_byte, out_last);
        end
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_byte !== 8'h7F || out_last !== 1'b1 || out_idx !== 4'd1) begin
            tests_failed++;
            $display("FAIL b2b_beat1 got rdy=%b byte=%h last=%b idx=%0d want 0/7f/1/1",
                     in_ready, out_byte, out_last, out_idx);
        end
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_bubble got rdy=%b valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_byte !== 8'h02 || out_last !== 1'b1 || out_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL b2b_next got valid=%b byte=%h last=%b idx=%0d want 1/02/1/0",
                     out_valid, out_byte, out_last, out_idx);
        end
        collect();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(64'hFFFF_FFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_idx !== 4'd2) begin
            tests_failed++;
            $display("FAIL rstmid_pre got valid=%b idx=%0d want 1/2", out_valid, out_idx);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 4'd0 || out_byte !== 8'h00) begin
            tests_failed++;
            $display("FAIL rstmid_async got valid=%b rdy=%b idx=%0d byte=%h want 0/1/0/00",
                     out_valid, in_ready, out_idx, out_byte);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rstmid_quiet%0d got valid=%b want 0", c, out_valid);
            end
        end
        send(64'd1);
        collect();
        tests_run++;
        if (cap_n !== 1 || cap_byte[0] !== 8'h01 || cap_last[0] !== 1'b1 || cap_idx[0] !== 4'd0) begin
            tests_failed++;
            $display("FAIL rstmid_next got n=%0d byte=%h last=%b idx=%0d want 1/01/1/0",
                     cap_n, cap_byte[0], cap_last[0], cap_idx[0]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_val    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_zero();
        test_300();
        test_zigzag();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
